// File: rtl/psum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : psum_pkg
// Description : Shared types and constants for the partial-sum accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package psum_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam int ACC_W_DEF   = 32;
    localparam int MAX_LEN_DEF = 16;
    localparam int CNT_W_DEF   = 5;
    localparam int TERM_W      = 32;

    // Clamp limits for the default accumulator width
    localparam logic [ACC_W_DEF-1:0] SAT_POS_DEF = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic [ACC_W_DEF-1:0] SAT_NEG_DEF = {1'b1, {(ACC_W_DEF-1){1'b0}}};

endpackage : psum_pkg
`default_nettype wire

// File: rtl/psum_sat_add.sv
`default_nettype none
// ============================================================================
// Module      : psum_sat_add
// Description : Combinational ACC_W+1-bit add of a sign-extended term to the
//               accumulator, with optional clamp and overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module psum_sat_add
    import psum_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [TERM_W-1:0] term,
    input  logic              sat_en,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    localparam logic [ACC_W-1:0] C_SAT_POS = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] C_SAT_NEG = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] w_acc_x;
    logic [ACC_W:0] w_term_x;
    logic [ACC_W:0] w_sum_x;

    assign w_acc_x  = {acc[ACC_W-1], acc};
    assign w_term_x = {{(ACC_W+1-TERM_W){term[TERM_W-1]}}, term};
    assign w_sum_x  = w_acc_x + w_term_x;

    // Top two bits disagree exactly when the true sum leaves the ACC_W range
    assign ovf = w_sum_x[ACC_W] ^ w_sum_x[ACC_W-1];

    always_comb begin
        sum = w_sum_x[ACC_W-1:0];
        if (sat_en && ovf) begin
            sum = w_sum_x[ACC_W] ? C_SAT_NEG : C_SAT_POS;
        end
    end

endmodule : psum_sat_add
`default_nettype wire

// File: rtl/psum_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : psum_accumulator
// Description : Accumulates a group of signed terms into a partial sum and
//               presents it on a registered valid/ready output.
//               Optional macro PSUM_ACC_SAT_EN enables saturating accumulation.
// Revision    : 1.0 - initial release
// ============================================================================
module psum_accumulator
    import psum_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TERM_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_sat
);

`ifdef PSUM_ACC_SAT_EN
    localparam logic C_SAT_EN = 1'b1;
`else
    localparam logic C_SAT_EN = 1'b0;
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_out_data;
    logic [CNT_W-1:0]   r_out_count;
    logic [ACC_W-1:0]   w_sum;
    logic               w_ovf;
    logic               w_accept;
    logic               w_close;

    psum_sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .acc    (r_acc),
        .term   (in_data),
        .sat_en (C_SAT_EN),
        .sum    (w_sum),
        .ovf    (w_ovf)
    );

    // clr discards any beat offered in the same cycle
    assign w_accept = in_valid && in_ready && !clr;
    assign w_close  = w_accept && (in_last || (r_cnt == CNT_W'(MAX_LEN - 1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ACCUM: begin
                in_ready = 1'b1;
                if (w_close) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ACCUM;
                end
            end
            default: w_state_nxt = ACCUM;
        endcase
        if (clr) begin
            w_state_nxt = ACCUM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_count <= '0;
        end else if (clr) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_close) begin
            r_out_data  <= w_sum;
            r_out_count <= r_cnt + CNT_W'(1);
            r_acc       <= '0;
            r_cnt       <= '0;
        end else if (w_accept) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

`ifdef PSUM_ACC_SAT_EN
    logic r_sat_flag;
    logic r_out_sat;

    // Sticky per-group flag; the closing term's own overflow is folded in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_flag <= 1'b0;
            r_out_sat  <= 1'b0;
        end else if (clr) begin
            r_sat_flag <= 1'b0;
            r_out_sat  <= 1'b0;
        end else if (w_close) begin
            r_out_sat  <= r_sat_flag | w_ovf;
            r_sat_flag <= 1'b0;
        end else if (w_accept) begin
            r_sat_flag <= r_sat_flag | w_ovf;
        end
    end

    assign out_sat = r_out_sat;
`else
    logic w_unused_ovf;
    assign w_unused_ovf = w_ovf;
    assign out_sat      = 1'b0;
`endif

    assign out_data  = r_out_data;
    assign out_count = r_out_count;

endmodule : psum_accumulator
`default_nettype wire

// File: tb/tb_psum_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_psum_accumulator
// Description : Directed self-checking bench for psum_accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psum_accumulator;

    localparam int ACC_W = 32;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_sat;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    psum_accumulator #(
        .ACC_W   (ACC_W),
        .MAX_LEN (16),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; out_ready = 1'b0;
        idle();
        step(); step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        chk("rst_out_sat",   64'(out_sat),   64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Group 5, -3, 10
        out_ready = 1'b1;
        step();
        beat(32'd5, 1'b0);           step();
        beat(-32'sd3, 1'b0);         step();
        chk("g1_no_early_valid", 64'(out_valid), 64'd0);
        beat(32'd10, 1'b1);          step();
        idle();
        chk("g1_valid_lat1", 64'(out_valid), 64'd1);
        chk("g1_data",       64'(out_data),  64'd12);
        chk("g1_count",      64'(out_count), 64'd3);
        chk("g1_sat",        64'(out_sat),   64'd0);
        chk("g1_in_ready",   64'(in_ready),  64'd0);
        step();
        chk("g1_hs_valid",   64'(out_valid), 64'd0);
        chk("g1_hs_ready",   64'(in_ready),  64'd1);

        // 16 ones without in_last: forced close
        out_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            beat(32'd1, 1'b0);
            step();
        end
        chk("g2_open_at_15", 64'(out_valid), 64'd0);
        step();
        chk("g2_valid", 64'(out_valid), 64'd1);
        chk("g2_data",  64'(out_data),  64'd16);
        chk("g2_count", 64'(out_count), 64'd16);

        // Back-pressure: held term must not be consumed while result pending
        beat(32'd7, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", 64'(in_ready),  64'd0);
            step();
        end
        chk("bp_data_stable",  64'(out_data),  64'd16);
        chk("bp_count_stable", 64'(out_count), 64'd16);
        chk("bp_valid_held",   64'(out_valid), 64'd1);
        out_ready = 1'b1;
        step();
        chk("bp_hs_valid", 64'(out_valid), 64'd0);
        chk("bp_hs_ready", 64'(in_ready),  64'd1);
        step();
        idle();
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_data",  64'(out_data),  64'd7);
        chk("single_count", 64'(out_count), 64'd1);
        step();

        // Overflow at the positive limit
        beat(32'h7FFF_FFFF, 1'b0);   step();
        beat(32'd1, 1'b1);           step();
        idle();
`ifdef PSUM_ACC_SAT_EN
        chk("ovf_data", 64'(out_data), 64'h7FFF_FFFF);
        chk("ovf_sat",  64'(out_sat),  64'd1);
`else
        chk("ovf_data", 64'(out_data), 64'h8000_0000);
        chk("ovf_sat",  64'(out_sat),  64'd0);
`endif
        chk("ovf_count", 64'(out_count), 64'd2);
        step();

        // clr with a concurrent beat: group and beat discarded
        beat(32'd7, 1'b0);           step();
        beat(32'd8, 1'b0);           step();
        beat(32'd100, 1'b1);
        clr = 1'b1;                  step();
        clr = 1'b0;
        idle();
        chk("clr_no_valid", 64'(out_valid), 64'd0);
        chk("clr_in_ready", 64'(in_ready),  64'd1);
        chk("clr_sat",      64'(out_sat),   64'd0);
        step();
        chk("clr_no_valid2", 64'(out_valid), 64'd0);
        beat(32'd4, 1'b1);           step();
        idle();
        chk("clr_next_data",  64'(out_data),  64'd4);
        chk("clr_next_count", 64'(out_count), 64'd1);
        step();

        // Asynchronous reset mid-group
        beat(32'd2, 1'b0);           step();
        idle();
        rst_n = 1'b0;
        #1;
        chk("arst_data",  64'(out_data),  64'd0);
        chk("arst_count", 64'(out_count), 64'd0);
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_sat",   64'(out_sat),   64'd0);
        step();
        rst_n = 1'b1;
        beat(32'd2, 1'b0);           step();
        beat(32'd2, 1'b1);           step();
        idle();
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_data",  64'(out_data),  64'd4);
        chk("post_rst_count", 64'(out_count), 64'd2);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_psum_accumulator
`default_nettype wire
